// File: rtl/score_display.sv
// score_display: 8-bit score to three-digit multiplexed 7-segment display.
// A sequential double-dabble converter produces BCD digits, which are held
// in display registers and scanned one digit slot per refresh period.
module score_display #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] score,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [7:0]  cap, cap_nxt;
    logic [7:0]  last_score, last_nxt;
    logic [11:0] bcd, bcd_nxt, bcd_adj;
    logic [19:0] dd_shift;
    logic [2:0]  iter, iter_nxt;
    logic [3:0]  hun, ten, one;
    logic [3:0]  hun_nxt, ten_nxt, one_nxt;

    logic [CW-1:0] refcnt;
    logic [1:0]    sel;
    logic          wrap;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Add-3 correction on each BCD nibble ahead of the shift.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            bcd_adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3
                                                        : bcd[i*4 +: 4];
        end
    end

    assign dd_shift = {bcd_adj, shreg} << 1;

    // Converter next-state: capture on change, shift 8 times, then commit.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cap_nxt   = cap;
        last_nxt  = last_score;
        bcd_nxt   = bcd;
        iter_nxt  = iter;
        hun_nxt   = hun;
        ten_nxt   = ten;
        one_nxt   = one;
        case (state)
            IDLE: begin
                if (score != last_score) begin
                    shreg_nxt = score;
                    cap_nxt   = score;
                    bcd_nxt   = '0;
                    iter_nxt  = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_nxt, shreg_nxt} = dd_shift;
                iter_nxt = iter + 3'd1;
                if (iter == 3'd7) state_nxt = DONE;
            end
            DONE: begin
                // Only this state touches the display digits, so partial
                // BCD values never reach the segments.
                hun_nxt   = bcd[11:8];
                ten_nxt   = bcd[7:4];
                one_nxt   = bcd[3:0];
                last_nxt  = cap;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Converter and display-digit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cap        <= '0;
            last_score <= '0;
            bcd        <= '0;
            iter       <= '0;
            hun        <= '0;
            ten        <= '0;
            one        <= '0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            cap        <= cap_nxt;
            last_score <= last_nxt;
            bcd        <= bcd_nxt;
            iter       <= iter_nxt;
            hun        <= hun_nxt;
            ten        <= ten_nxt;
            one        <= one_nxt;
        end
    end

    assign busy = (state != IDLE);
    assign wrap = (refcnt == CW'(REFRESH_DIV - 1));

    // Refresh divider and digit-slot select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refcnt <= '0;
            sel    <= '0;
        end else if (wrap) begin
            refcnt <= '0;
            sel    <= sel + 2'd1;
        end else begin
            refcnt <= refcnt + 1'b1;
        end
    end

    // Slot decode with optional leading-zero blanking.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        case (sel)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = seg7(one);
            end
            2'd1: begin
                if (!(BLANK_LZ && hun == 4'd0 && ten == 4'd0)) begin
                    an_d  = 4'b1101;
                    seg_d = seg7(ten);
                end
            end
            2'd2: begin
                if (!(BLANK_LZ && hun == 4'd0)) begin
                    an_d  = 4'b1011;
                    seg_d = seg7(hun);
                end
            end
            default: ;
        endcase
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: checks two score_display instances (blanking on/off)
// against a value-level display model every cycle, plus literal spot checks.
module tb_score_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] score = 8'd0;
    logic [3:0] an1, an0;
    logic [6:0] seg1, seg0;
    logic       dp1, dp0, busy1, busy0;

    int total = 0;
    int bad   = 0;

    score_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .score(score),
        .an(an1), .seg(seg1), .dp(dp1), .busy(busy1));

    score_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .score(score),
        .an(an0), .seg(seg0), .dp(dp0), .busy(busy0));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Segment pattern for a decimal digit, from the segment table.
    function automatic logic [6:0] digit_seg(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tbl[d];
    endfunction

    // What a slot shows for a displayed value.
    task automatic slot_view(input int v, input int slot, input bit blz,
                             output logic [3:0] a, output logic [6:0] s);
        int h, t, o;
        h = v / 100; t = (v / 10) % 10; o = v % 10;
        a = 4'b1111; s = 7'b1111111;
        if (slot == 0) begin
            a = 4'b1110; s = digit_seg(o);
        end else if (slot == 1 && !(blz && h == 0 && t == 0)) begin
            a = 4'b1101; s = digit_seg(t);
        end else if (slot == 2 && !(blz && h == 0)) begin
            a = 4'b1011; s = digit_seg(h);
        end
    endtask

    // Model: the display shows the last committed value; a change seen while
    // idle is committed 10 edges later; slot = (edges since reset / DIV) % 4.
    int m_tick, m_left, m_conv, m_last, m_disp;

    always @(negedge clk) begin
        logic [3:0] ea1, ea0;
        logic [6:0] es1, es0;
        if (!rst_n) begin
            m_tick = 0; m_left = 0; m_conv = 0; m_last = 0; m_disp = 0;
            chk("rst_an", an1, 4'hF);
            chk("rst_seg", seg1, 7'h7F);
            chk("rst_busy", busy1, 0);
            chk("rst_dp", dp1, 1);
        end else begin
            slot_view(m_disp, (m_tick / DIV) % 4, 1'b1, ea1, es1);
            slot_view(m_disp, (m_tick / DIV) % 4, 1'b0, ea0, es0);
            if (m_left == 0) begin
                if (int'(score) != m_last) begin
                    m_left = 9;
                    m_conv = score;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_disp = m_conv;
                    m_last = m_conv;
                end
            end
            m_tick++;
            chk("an_blz1", an1, ea1);
            chk("seg_blz1", seg1, es1);
            chk("an_blz0", an0, ea0);
            chk("seg_blz0", seg0, es0);
            chk("busy", busy1, int'(m_left != 0));
            chk("busy_blz0", busy0, int'(m_left != 0));
            chk("dp", dp1, 1);
            chk("dp_blz0", dp0, 1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Wait (bounded) for a slot to light on one instance and check its pattern.
    task automatic check_slot(input string name, input bit which0,
                              input logic [3:0] a, input logic [6:0] s);
        bit seen = 0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(negedge clk); #2;
            if ((which0 ? an0 : an1) == a) begin
                seen = 1;
                chk(name, which0 ? seg0 : seg1, s);
            end
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
        @(negedge clk); #1;
    endtask

    initial begin
        int cnt;
        cyc(2);
        rst_n = 1'b1;

        // Score 0: only the ones slot lights, 12 of 16 cycles dark.
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #2;
            if (an1 == 4'b1111) cnt++;
        end
        chk("zero_dark_cycles", cnt, 12);
        check_slot("zero_ones", 0, 4'b1110, 7'b1000000);

        // 0 -> 255: nine busy cycles, digits 2,5,5.
        score = 8'd255;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); #2;
            if (busy1) cnt++;
        end
        chk("busy_len", cnt, 9);
        check_slot("255_hun", 0, 4'b1011, 7'b0100100);
        check_slot("255_ten", 0, 4'b1101, 7'b0010010);
        check_slot("255_one", 0, 4'b1110, 7'b0010010);

        // 107: inner zero is shown.
        @(negedge clk); #1;
        score = 8'd107;
        cyc(12);
        check_slot("107_hun", 0, 4'b1011, 7'b1111001);
        check_slot("107_ten", 0, 4'b1101, 7'b1000000);
        check_slot("107_one", 0, 4'b1110, 7'b1111000);

        // 9 then 42 mid-conversion.
        score = 8'd9;
        cyc(3);
        score = 8'd42;
        cyc(25);
        check_slot("42_ten", 0, 4'b1101, 7'b0011001);
        check_slot("42_one", 0, 4'b1110, 7'b0100100);

        // Reset during SHIFT with 200 pending.
        score = 8'd200;
        cyc(4);
        rst_n = 1'b0;
        #1;
        chk("async_an", an1, 4'hF);
        chk("async_seg", seg1, 7'h7F);
        chk("async_busy", busy1, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(14);
        check_slot("200_hun", 0, 4'b1011, 7'b0100100);
        check_slot("200_ten", 0, 4'b1101, 7'b1000000);
        check_slot("200_one", 0, 4'b1110, 7'b1000000);

        // 5 with blanking off: 0,0,5 all lit.
        score = 8'd5;
        cyc(12);
        check_slot("nb_hun", 1, 4'b1011, 7'b1000000);
        check_slot("nb_ten", 1, 4'b1101, 7'b1000000);
        check_slot("nb_one", 1, 4'b1110, 7'b0010010);
        cyc(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
